sram1p_rw_regaddr: RTL and testbench
====================================

# sram1p_rw_regaddr

Single-port synchronous RAM with chip enable, whole-word write enable and a registered read address, used for cache data and tag subarrays (I$ data, RV32/RV64 tags). Read data comes combinationally from the word selected by the address captured at the last enabled clock edge. The same address port serves reads and writes. A behavioral array is the default; technology SRAM macros are substituted for recognised geometries.

## Interface
- DEPTH, 64, number of words; address width is clog2(DEPTH).
- WIDTH, 44, bits per word.
- USE_SRAM, 0, 1 selects an SRAM macro when (WIDTH, DEPTH) is (128,64), (44,64) or (22,64); otherwise behavioral.
- clk  input  1  rising-edge clock, sole clock domain.
- reset  input  1  asynchronous, active-low reset.
- ce  input  1  chip enable; gates address capture and writes.
- addr  input  clog2(DEPTH)  word address for both read and write.
- din  input  WIDTH  write data.
- we  input  1  write enable, effective only with ce=1.
- dout  output  WIDTH  read data = RAM[registered address].

## Operation
- Address register addrd: on a rising edge with ce=1, addrd <= addr. With ce=0 it holds.
- Read: dout = RAM[addrd], combinational from addrd and the array. No output register.
- Write: on a rising edge with ce=1 and we=1, RAM[addr] <= din, full word. No byte enables.
- we=1 with ce=0: no write and no address capture. Read-only caches never issue this combination.
- Same-edge write and capture to the same address: the array and addrd update on the same edge, so dout shows the new din after that edge.
- While ce=0, dout is stable, because neither addrd nor the array can change.
- Reset (reset=0, asynchronous): addrd is forced to 0 immediately and held while reset is low. Array contents are not reset. During and after reset, dout = RAM[0], which is X until written.
- Reset release takes effect at the next rising edge, with normal ce/we semantics.
- Macro path: the macro pins are tied as CEB=~ce, WEB=~we, BWEB=all zeros (all bits enabled), A=addr, D=din, Q=dout. The macro keeps the same one-cycle read latency.

## Timing
- Read latency: 1 cycle. Address presented with ce=1 at edge N gives valid dout after edge N, in cycle N+1, through combinational array read.
- Write latency: data is visible on dout in the cycle after the write edge if addrd selects that address.
- Back-to-back operations at full rate: a new address is accepted every enabled cycle.
- No handshake. No stall other than ce.

## Structure
- Sub-module flopen(WIDTH=clog2(DEPTH)) holds addrd. Its ports are clk, reset, en, d, q, with asynchronous active-low clear to 0.
- Generate branches:
  - 64x128, 64x44 and 64x22 macro wrappers (ram1p1rwbe_64x128, ram1p1rwbe_64x44, ram1p1rwbe_64x22) when USE_SRAM=1;
  - the behavioral array otherwise.
- The array is written from a plain clocked always block, not always_ff, so the array can be driven from more than one procedural block.
- No package types are required. Geometry constants stay as module parameters.

## Test plan
- Reset: assert reset=0 mid-run with addrd=5; addrd must go to 0 immediately, without waiting for a clock edge.
- Write then read: with ce=1, we=1, write addr=3, din=0xABC, then addr=7, din=0x123. Then with we=0, set addr=3. After the next edge dout=0xABC; after the following edge with addr=7, dout=0x123.
- Same-edge write/capture: ce=1, we=1, addr=10, din=0x55 over a location previously holding 0x11. After that edge dout=0x55.
- Enable hold: read addr=3 (dout=0xABC), then drop ce and change addr to 7 with we=1, din=0xFFF over several edges. dout must stay 0xABC, and a later read of addr=7 must return 0x123.
- Full sweep: write RAM[i]=i*0x9 for i=0..63, read back sequentially one per cycle. Each dout must match, one cycle after its address.
- Boundary: write and read addr=0 and addr=63 with all-ones and all-zeros din (WIDTH=44 and WIDTH=128 builds). Data must read back exactly, with no aliasing.

Source files
------------

// File: rtl/sram1p_rw_regaddr_pkg.sv
// Shared helpers for the single-port RAM with registered read address.
package sram1p_rw_regaddr_pkg;

    // True when a technology macro exists for this word width and depth.
    function automatic bit macro_geom_ok(input int width, input int depth);
        return (depth == 64) && (width == 128 || width == 44 || width == 22);
    endfunction

endpackage

// File: rtl/sram1p_rw_regaddr_flopen.sv
// Enabled register with asynchronous active-low clear; holds the read address.
module flopen #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sram1p_rw_regaddr_macros.sv
// Simulation stand-ins for the 64-word single-port macros with bit-write enables.
// Pins are active low: CEB, WEB, and BWEB (0 = bit written).
module ram1p1rwbe_model #(
    parameter int W = 44,
    parameter int D = 64
) (
    input  logic                 CLK,
    input  logic                 CEB,
    input  logic                 WEB,
    input  logic [$clog2(D)-1:0] A,
    input  logic [W-1:0]         D_IN,
    input  logic [W-1:0]         BWEB,
    output logic [W-1:0]         Q
);

    logic [W-1:0]         mem [D];
    logic [$clog2(D)-1:0] a_q;

    always @(posedge CLK) begin
        if (!CEB) begin
            a_q <= A;
            if (!WEB) mem[A] <= (mem[A] & BWEB) | (D_IN & ~BWEB);
        end
    end

    assign Q = mem[a_q];

endmodule

module ram1p1rwbe_64x128 (
    input  logic         CLK, CEB, WEB,
    input  logic [5:0]   A,
    input  logic [127:0] D, BWEB,
    output logic [127:0] Q
);
    ram1p1rwbe_model #(.W(128), .D(64)) u_model (
        .CLK(CLK), .CEB(CEB), .WEB(WEB), .A(A), .D_IN(D), .BWEB(BWEB), .Q(Q));
endmodule

module ram1p1rwbe_64x44 (
    input  logic        CLK, CEB, WEB,
    input  logic [5:0]  A,
    input  logic [43:0] D, BWEB,
    output logic [43:0] Q
);
    ram1p1rwbe_model #(.W(44), .D(64)) u_model (
        .CLK(CLK), .CEB(CEB), .WEB(WEB), .A(A), .D_IN(D), .BWEB(BWEB), .Q(Q));
endmodule

module ram1p1rwbe_64x22 (
    input  logic        CLK, CEB, WEB,
    input  logic [5:0]  A,
    input  logic [21:0] D, BWEB,
    output logic [21:0] Q
);
    ram1p1rwbe_model #(.W(22), .D(64)) u_model (
        .CLK(CLK), .CEB(CEB), .WEB(WEB), .A(A), .D_IN(D), .BWEB(BWEB), .Q(Q));
endmodule

// File: rtl/sram1p_rw_regaddr.sv
// Single-port RAM: address captured on enabled edges, read combinationally from
// the captured address. Recognised geometries can map onto a technology macro.
module sram1p_rw_regaddr
    import sram1p_rw_regaddr_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int WIDTH    = 44,
    parameter int USE_SRAM = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ce,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         din,
    input  logic                     we,
    output logic [WIDTH-1:0]         dout
);

    localparam bit UseMacro = (USE_SRAM != 0) && macro_geom_ok(WIDTH, DEPTH);

    if (UseMacro && WIDTH == 128) begin : g_m128
        ram1p1rwbe_64x128 u_sram (
            .CLK(clk), .CEB(~ce), .WEB(~we), .A(addr), .D(din),
            .BWEB('0), .Q(dout));
    end else if (UseMacro && WIDTH == 44) begin : g_m44
        ram1p1rwbe_64x44 u_sram (
            .CLK(clk), .CEB(~ce), .WEB(~we), .A(addr), .D(din),
            .BWEB('0), .Q(dout));
    end else if (UseMacro && WIDTH == 22) begin : g_m22
        ram1p1rwbe_64x22 u_sram (
            .CLK(clk), .CEB(~ce), .WEB(~we), .A(addr), .D(din),
            .BWEB('0), .Q(dout));
    end else begin : g_beh
        logic [WIDTH-1:0]         mem [DEPTH];
        logic [$clog2(DEPTH)-1:0] addr_q;

        flopen #(.WIDTH($clog2(DEPTH))) u_addr_reg (
            .clk(clk), .reset(reset), .en(ce), .d(addr), .q(addr_q));

        // Plain always so other procedural blocks (e.g. preload) may also drive mem.
        always @(posedge clk) begin
            if (ce && we) mem[addr] <= din;
        end

        assign dout = mem[addr_q];
    end

endmodule

// File: tb/tb_sram1p_rw_regaddr.sv
// Directed bench for sram1p_rw_regaddr (64 x 44, behavioral array).
module tb_sram1p_rw_regaddr;

    localparam int W = 44;
    localparam int AW = 6;
    localparam logic [W-1:0] ONES = {W{1'b1}};
    localparam logic [W-1:0] ZERO = '0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [W-1:0]  din = '0;
    logic [W-1:0]  dout;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sram1p_rw_regaddr #(.DEPTH(64), .WIDTH(W), .USE_SRAM(0)) dut (
        .clk(clk), .reset(rst_n), .ce(ce), .addr(addr), .din(din),
        .we(we), .dout(dout));

    // Apply one set of inputs across a rising edge; return 1 time unit after it.
    task automatic op(input logic c, input logic w, input logic [AW-1:0] a,
                      input logic [W-1:0] d);
        ce = c; we = w; addr = a; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] exp);
        vectors++;
        assert (dout === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, dout, exp);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        op(1, 1, 6'd0, 44'h0A0);  check("post_reset_w0", 44'h0A0);
        op(1, 1, 6'd5, 44'h555);  check("write5", 44'h555);
        op(0, 0, 6'd0, 44'h0);    check("idle_hold5", 44'h555);

        // Asynchronous reset mid-cycle: address snaps to 0 without an edge.
        #2 rst_n = 1'b0;
        #1 check("async_reset", 44'h0A0);
        op(1, 0, 6'd5, 44'h0);    check("reset_held", 44'h0A0);
        #2 rst_n = 1'b1;
        op(1, 0, 6'd5, 44'h0);    check("after_release", 44'h555);

        op(1, 1, 6'd3, 44'hABC);  check("write3", 44'hABC);
        op(1, 1, 6'd7, 44'h123);  check("write7", 44'h123);
        op(1, 0, 6'd3, 44'h0);    check("read3", 44'hABC);
        op(1, 0, 6'd7, 44'h0);    check("read7", 44'h123);

        op(1, 1, 6'd10, 44'h11);  check("write10_old", 44'h11);
        op(1, 1, 6'd10, 44'h55);  check("same_edge10", 44'h55);

        op(1, 0, 6'd3, 44'h0);    check("hold_read3", 44'hABC);
        for (int k = 0; k < 3; k++) begin
            op(0, 1, 6'd7, 44'hFFF);
            check($sformatf("ce_low_hold%0d", k), 44'hABC);
        end
        op(1, 0, 6'd7, 44'h0);    check("read7_unwritten", 44'h123);

        for (int i = 0; i < 64; i++) op(1, 1, AW'(i), W'(i * 9));
        for (int i = 0; i < 64; i++) begin
            op(1, 0, AW'(i), 44'h0);
            check($sformatf("sweep%0d", i), W'(i * 9));
        end

        op(1, 1, 6'd0, ONES);     check("b0_ones_w", ONES);
        op(1, 1, 6'd63, ZERO);    check("b63_zero_w", ZERO);
        op(1, 0, 6'd0, 44'h0);    check("b0_ones_r", ONES);
        op(1, 0, 6'd63, 44'h0);   check("b63_zero_r", ZERO);
        op(1, 1, 6'd0, ZERO);     check("b0_zero_w", ZERO);
        op(1, 1, 6'd63, ONES);    check("b63_ones_w", ONES);
        op(1, 0, 6'd0, 44'h0);    check("b0_zero_r", ZERO);
        op(1, 0, 6'd63, 44'h0);   check("b63_ones_r", ONES);
        op(1, 0, 6'd1, 44'h0);    check("no_alias1", 44'd9);
        op(1, 0, 6'd62, 44'h0);   check("no_alias62", 44'd558);
        op(1, 0, 6'd32, 44'h0);   check("no_alias32", 44'd288);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
